bcd_to_signed_seq: RTL and testbench
====================================

// Module: bcd_to_signed_seq
// PURPOSE
//  Sequential decimal-to-binary converter: takes NDIG packed BCD digits plus a sign
//  flag and produces a saturated two's-complement value of WIDTH bits.
//  Feeds the CORDIC angle path from decimal (switch/keypad) entry, converting
//  sign/magnitude decimal back into the signed binary the datapath consumes.
//  Uses Horner accumulation, one digit per clock, with a start/done handshake.
// PARAMETERS
//  NDIG   5   number of BCD digits; digit NDIG-1 is the most significant
//  WIDTH  17  width of the signed result
// PORTS
//  clk_50    in   1          system clock; all state changes on its rising edge
//  Reset     in   1          synchronous reset, active low
//  start     in   1          active-high request; sampled only in IDLE
//  bcd_in    in   4*NDIG     packed digits; [3:0] = units
//  sig_in    in   1          1 = positive/zero, 0 = negative
//  data_out  out  WIDTH      signed result; held until the next accepted start
//  busy      out  1          high from the cycle after an accepted start until done
//  done      out  1          one-cycle pulse when data_out/ovf/err become valid
//  ovf       out  1          magnitude exceeded range; data_out is saturated
//  err       out  1          some digit > 9; data_out = 0, ovf = 0
// BEHAVIOUR
//  Reset (Reset==0 at a clock edge, any state) -> IDLE; data_out=0, busy=0,
//    done=0, ovf=0, err=0; an in-flight conversion is discarded.
//  FSM states: IDLE -> CONV -> FIX -> DONE -> IDLE.
//  IDLE: when start==1, capture bcd_in and sig_in into internal registers,
//    clear acc (4*NDIG bits, unsigned), set digit index i=NDIG-1, go to CONV.
//    Inputs are not sampled again until the next IDLE.
//  CONV: each cycle acc <= (acc<<3) + (acc<<1) + digit[i]; i decrements.
//    The state is left after NDIG cycles. A digit > 9 sets an internal error flag;
//    accumulation still runs the full NDIG cycles.
//  FIX (1 cycle): let MAXP = 2^(WIDTH-1)-1 and MAXN = 2^(WIDTH-1).
//    error       -> data_out = 0, err = 1, ovf = 0
//    positive    -> acc > MAXP ? (MAXP, ovf=1) : (acc, ovf=0)
//    negative    -> acc > MAXN ? (-MAXN, ovf=1) : (-acc, ovf=0); -0 = 0
//    ovf and err are updated only here; they hold until the next FIX or reset.
//  DONE: done=1 for exactly one cycle; next state IDLE.
//  Latency: start seen at edge 0 -> busy=1 on cycles 1..NDIG+1 -> done=1 on cycle
//    NDIG+2 (cycle 7 for NDIG=5) -> busy=0 in that same cycle.
//  A start asserted while busy or in DONE is ignored; it is not queued.
//  Start held high continuously -> back-to-back conversions, one every NDIG+3 cycles.
//  data_out keeps its old value through CONV and changes only at FIX.
// TESTING
//  T1 bcd=5'h12345 digits, sig=1, start pulse -> done on cycle 7, data_out=12345 (17'h03039), ovf=0, err=0
//  T2 bcd=00700, sig=0 -> data_out=-700 (17'h1FD44); bcd=00000, sig=0 -> data_out=0
//  T3 bcd=99999, sig=1 -> data_out=65535, ovf=1; bcd=65536, sig=0 -> -65536, ovf=0;
//     bcd=65537, sig=0 -> -65536, ovf=1
//  T4 bcd=1A345 (digit 3 = 0xA) -> data_out=0, err=1, ovf=0; the next valid conversion clears err
//  T5 start re-pulsed during CONV -> ignored, exactly one done; start held high ->
//     done every 8 cycles
//  T6 Reset low on cycle 3 of CONV -> next cycle: IDLE, all outputs 0, no done pulse;
//     a later start converts normally

Source files
------------

// File: rtl/bcd_to_signed_seq_if.sv
// Handshake and data bundle between a decimal-entry front end and the
// BCD-to-signed converter.
interface bcd_to_signed_seq_if #(
    parameter int NDIG  = 5,
    parameter int WIDTH = 17
);
    logic                start;
    logic [4*NDIG-1:0]   bcd_in;
    logic                sig_in;
    logic [WIDTH-1:0]    data_out;
    logic                busy;
    logic                done;
    logic                ovf;
    logic                err;

    modport master (
        output start, bcd_in, sig_in,
        input  data_out, busy, done, ovf, err
    );

    modport slave (
        input  start, bcd_in, sig_in,
        output data_out, busy, done, ovf, err
    );
endinterface

// File: rtl/bcd_to_signed_seq.sv
// Sequential sign/magnitude BCD to saturated two's-complement converter.
// Horner accumulation, one digit per clock, MSD first; result settles in FIX.
module bcd_to_signed_seq #(
    parameter int NDIG  = 5,
    parameter int WIDTH = 17
) (
    input  logic               clk_50,
    input  logic               Reset,
    bcd_to_signed_seq_if.slave bus
);
    localparam int AW = 4 * NDIG;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int CW = ((AW > WIDTH) ? AW : WIDTH) + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Range limits compared in a width that holds both the accumulator and MAXN.
    localparam logic [CW-1:0]    MAXP    = (CW'(1) << (WIDTH - 1)) - CW'(1);
    localparam logic [CW-1:0]    MAXN    = CW'(1) << (WIDTH - 1);
    localparam logic [WIDTH-1:0] SAT_POS = ~(WIDTH'(1) << (WIDTH - 1));
    localparam logic [WIDTH-1:0] SAT_NEG = WIDTH'(1) << (WIDTH - 1);

    logic [1:0]       state_reg, state_next;
    logic [AW-1:0]    bcd_reg,   bcd_next;
    logic             sig_reg,   sig_next;
    logic [AW-1:0]    acc_reg,   acc_next;
    logic [IW-1:0]    idx_reg,   idx_next;
    logic             bad_reg,   bad_next;
    logic [WIDTH-1:0] data_reg,  data_next;
    logic             ovf_reg,   ovf_next;
    logic             err_reg,   err_next;

    logic [3:0]       digit_term [NDIG];
    logic [3:0]       cur_digit;
    logic [CW-1:0]    acc_ext;
    logic [WIDTH-1:0] fix_data;
    logic             fix_ovf;

    // One-hot digit select avoids indexing past NDIG with a power-of-two counter.
    generate
        for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
            assign digit_term[gi] = (idx_reg == IW'(gi)) ? bcd_reg[4*gi +: 4] : 4'd0;
        end
    endgenerate

    always_comb begin
        cur_digit = 4'd0;
        for (int k = 0; k < NDIG; k++) begin
            cur_digit = cur_digit | digit_term[k];
        end
    end

    assign acc_ext = {{(CW-AW){1'b0}}, acc_reg};

    always_comb begin
        fix_data = '0;
        fix_ovf  = 1'b0;
        if (bad_reg) begin
            fix_data = '0;
            fix_ovf  = 1'b0;
        end else if (sig_reg) begin
            if (acc_ext > MAXP) begin
                fix_data = SAT_POS;
                fix_ovf  = 1'b1;
            end else begin
                fix_data = acc_ext[WIDTH-1:0];
            end
        end else begin
            if (acc_ext > MAXN) begin
                fix_data = SAT_NEG;
                fix_ovf  = 1'b1;
            end else begin
                fix_data = ~acc_ext[WIDTH-1:0] + WIDTH'(1);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        bcd_next   = bcd_reg;
        sig_next   = sig_reg;
        acc_next   = acc_reg;
        idx_next   = idx_reg;
        bad_next   = bad_reg;
        data_next  = data_reg;
        ovf_next   = ovf_reg;
        err_next   = err_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    bcd_next   = bus.bcd_in;
                    sig_next   = bus.sig_in;
                    acc_next   = '0;
                    idx_next   = IW'(NDIG - 1);
                    bad_next   = 1'b0;
                    state_next = ST_CONV;
                end
            end
            ST_CONV: begin
                acc_next = (acc_reg << 3) + (acc_reg << 1) + AW'(cur_digit);
                if (cur_digit > 4'd9) begin
                    bad_next = 1'b1;
                end
                idx_next = idx_reg - IW'(1);
                if (idx_reg == '0) begin
                    state_next = ST_FIX;
                end
            end
            ST_FIX: begin
                data_next  = fix_data;
                ovf_next   = fix_ovf;
                err_next   = bad_reg;
                state_next = ST_DONE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_50) begin
        if (!Reset) begin
            state_reg <= ST_IDLE;
            bcd_reg   <= '0;
            sig_reg   <= 1'b0;
            acc_reg   <= '0;
            idx_reg   <= '0;
            bad_reg   <= 1'b0;
            data_reg  <= '0;
            ovf_reg   <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            bcd_reg   <= bcd_next;
            sig_reg   <= sig_next;
            acc_reg   <= acc_next;
            idx_reg   <= idx_next;
            bad_reg   <= bad_next;
            data_reg  <= data_next;
            ovf_reg   <= ovf_next;
            err_reg   <= err_next;
        end
    end

    assign bus.data_out = data_reg;
    assign bus.ovf      = ovf_reg;
    assign bus.err      = err_reg;
    assign bus.busy     = (state_reg == ST_CONV) || (state_reg == ST_FIX);
    assign bus.done     = (state_reg == ST_DONE);

endmodule

// File: tb/tb_bcd_to_signed_seq.sv
// Directed bench for bcd_to_signed_seq: vector table plus hand-written
// sequences for start re-pulse, held start and mid-conversion reset.
module tb_bcd_to_signed_seq;
    localparam int NDIG  = 5;
    localparam int WIDTH = 17;

    typedef struct {
        logic [19:0] bcd;
        logic        sig;
        logic [16:0] exp_data;
        logic        exp_ovf;
        logic        exp_err;
    } vec_t;

    logic clk_50;
    logic Reset;
    int   n_tests;
    int   n_fail;
    logic [16:0] prev_data;

    bcd_to_signed_seq_if #(.NDIG(NDIG), .WIDTH(WIDTH)) bus ();

    bcd_to_signed_seq #(.NDIG(NDIG), .WIDTH(WIDTH)) dut (
        .clk_50 (clk_50),
        .Reset  (Reset),
        .bus    (bus)
    );

    initial clk_50 = 1'b0;
    always #10 clk_50 = ~clk_50;

    task automatic tick();
        @(posedge clk_50);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issues one start pulse and follows the conversion to its done pulse.
    task automatic run_conv(input logic [19:0] bcd, input logic sig, output int lat);
        bus.start  = 1'b1;
        bus.bcd_in = bcd;
        bus.sig_in = sig;
        tick();
        bus.start  = 1'b0;
        bus.bcd_in = 20'hFFFFF;
        bus.sig_in = ~sig;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            if (k == 1) begin
                check("busy_cycle1", {31'd0, bus.busy}, 32'd1);
                check("hold_cycle1", {15'd0, bus.data_out}, {15'd0, prev_data});
            end
            if (k == NDIG + 1) begin
                check("hold_fix", {15'd0, bus.data_out}, {15'd0, prev_data});
            end
            if (bus.done) begin
                lat = k;
                check("busy_at_done", {31'd0, bus.busy}, 32'd0);
                break;
            end
            tick();
        end
    endtask

    vec_t vecs [13];

    initial begin
        int lat;
        int done_cnt;
        int first_done;
        int last_done;
        int gap_bad;

        vecs[0]  = '{20'h12345, 1'b1, 17'h03039, 1'b0, 1'b0};
        vecs[1]  = '{20'h00700, 1'b0, 17'h1FD44, 1'b0, 1'b0};
        vecs[2]  = '{20'h00000, 1'b0, 17'h00000, 1'b0, 1'b0};
        vecs[3]  = '{20'h99999, 1'b1, 17'h0FFFF, 1'b1, 1'b0};
        vecs[4]  = '{20'h65536, 1'b0, 17'h10000, 1'b0, 1'b0};
        vecs[5]  = '{20'h65537, 1'b0, 17'h10000, 1'b1, 1'b0};
        vecs[6]  = '{20'h1A345, 1'b1, 17'h00000, 1'b0, 1'b1};
        vecs[7]  = '{20'h00001, 1'b1, 17'h00001, 1'b0, 1'b0};
        vecs[8]  = '{20'h99999, 1'b0, 17'h10000, 1'b1, 1'b0};
        vecs[9]  = '{20'h65535, 1'b1, 17'h0FFFF, 1'b0, 1'b0};
        vecs[10] = '{20'h65536, 1'b1, 17'h0FFFF, 1'b1, 1'b0};
        vecs[11] = '{20'h00001, 1'b0, 17'h1FFFF, 1'b0, 1'b0};
        vecs[12] = '{20'h0000F, 1'b0, 17'h00000, 1'b0, 1'b1};

        n_tests    = 0;
        n_fail     = 0;
        prev_data  = 17'd0;
        bus.start  = 1'b0;
        bus.bcd_in = 20'h0;
        bus.sig_in = 1'b1;
        Reset      = 1'b0;
        tick();
        tick();
        check("rst_data", {15'd0, bus.data_out}, 32'd0);
        check("rst_flags", {28'd0, bus.busy, bus.done, bus.ovf, bus.err}, 32'd0);
        Reset = 1'b1;
        tick();

        for (int v = 0; v < 13; v++) begin
            run_conv(vecs[v].bcd, vecs[v].sig, lat);
            check("latency", lat, 32'd7);
            check("data_out", {15'd0, bus.data_out}, {15'd0, vecs[v].exp_data});
            check("ovf", {31'd0, bus.ovf}, {31'd0, vecs[v].exp_ovf});
            check("err", {31'd0, bus.err}, {31'd0, vecs[v].exp_err});
            $display("[TB] vec %0d bcd=%05h sig=%b data=%05h ovf=%b err=%b latency=%0d",
                     v, vecs[v].bcd, vecs[v].sig, bus.data_out, bus.ovf, bus.err, lat);
            prev_data = vecs[v].exp_data;
            tick();
            check("done_one_cycle", {31'd0, bus.done}, 32'd0);
        end

        // Start re-pulsed during CONV must be ignored.
        bus.start  = 1'b1;
        bus.bcd_in = 20'h00123;
        bus.sig_in = 1'b1;
        tick();
        bus.start  = 1'b0;
        done_cnt   = 0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 3) begin
                bus.start  = 1'b1;
                bus.bcd_in = 20'h00999;
            end else begin
                bus.start  = 1'b0;
            end
            if (bus.done) done_cnt++;
            tick();
        end
        check("repulse_dones", done_cnt, 32'd1);
        check("repulse_data", {15'd0, bus.data_out}, 32'd123);
        $display("[TB] repulse dones=%0d data=%05h", done_cnt, bus.data_out);

        // Held start: back-to-back conversions every NDIG+3 cycles.
        bus.start  = 1'b1;
        bus.bcd_in = 20'h00042;
        bus.sig_in = 1'b0;
        tick();
        done_cnt   = 0;
        first_done = -1;
        last_done  = -1;
        gap_bad    = 0;
        for (int k = 1; k <= 30; k++) begin
            if (bus.done) begin
                if (first_done < 0) first_done = k;
                if (last_done >= 0 && (k - last_done) != 8) gap_bad++;
                last_done = k;
                done_cnt++;
            end
            tick();
        end
        bus.start = 1'b0;
        check("held_dones", done_cnt, 32'd3);
        check("held_first", first_done, 32'd7);
        check("held_gap", gap_bad, 32'd0);
        check("held_data", {15'd0, bus.data_out}, {15'd0, 17'h1FFD6});
        $display("[TB] held start dones=%0d first=%0d data=%05h", done_cnt, first_done, bus.data_out);
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            if (!bus.busy && !bus.done) begin
                lat = k;
                break;
            end
            tick();
        end
        check("held_drain", {31'd0, lat < 0}, 32'd0);

        // Leave nonzero data and ovf, then reset in the middle of CONV.
        prev_data = 17'h1FFD6;
        run_conv(20'h99999, 1'b1, lat);
        check("pre_rst_ovf", {31'd0, bus.ovf}, 32'd1);
        tick();
        bus.start  = 1'b1;
        bus.bcd_in = 20'h12345;
        bus.sig_in = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        Reset = 1'b0;
        tick();
        check("midrst_data", {15'd0, bus.data_out}, 32'd0);
        check("midrst_flags", {28'd0, bus.busy, bus.done, bus.ovf, bus.err}, 32'd0);
        Reset    = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            if (bus.done) done_cnt++;
            tick();
        end
        check("midrst_nodone", done_cnt, 32'd0);
        $display("[TB] mid-conversion reset data=%05h dones_after=%0d", bus.data_out, done_cnt);

        prev_data = 17'd0;
        run_conv(20'h00700, 1'b0, lat);
        check("post_rst_lat", lat, 32'd7);
        check("post_rst_data", {15'd0, bus.data_out}, {15'd0, 17'h1FD44});
        $display("[TB] post-reset conversion data=%05h latency=%0d", bus.data_out, lat);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
